// File: rtl/bcd_stopwatch_mux_if.sv
// Control and display bundle of the stopwatch core.
// master: board/top side that drives the controls and reads the display pins.
// slave : the stopwatch core itself.
interface bcd_stopwatch_mux_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  upDown;
  logic                  clear;
  logic                  lap;
  logic [DIGITS-1:0]     an;
  logic [7:0]            sgm;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  wrap;

  modport master (
    output enable, upDown, clear, lap,
    input  an, sgm, count_bcd, wrap
  );

  modport slave (
    input  enable, upDown, clear, lap,
    output an, sgm, count_bcd, wrap
  );
endinterface

// File: rtl/bcd_stopwatch_mux.sv
// Stopwatch core: tick prescaler, N-digit BCD up/down counter with wrap pulse,
// lap-hold snapshot and a time-multiplexed active-low 7-segment driver.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// above DP_DIGIT; without it every digit is always shown.
// DIV = CLK_HZ/TICK_HZ and SCAN_DIV = CLK_HZ/SCAN_HZ must both be >= 2.
module bcd_stopwatch_mux #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4,
  parameter int DP_DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  bcd_stopwatch_mux_if.slave bus
);

  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW       = $clog2(DIV);
  localparam int SW       = $clog2(SCAN_DIV);
  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW       = 4 * DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] ALL_NINES  = {DIGITS{4'h9}};
  localparam logic [CW-1:0] ALL_ZERO   = {CW{1'b0}};

  // Active-low {g,f,e,d,c,b,a} pattern of a decimal digit; codes 10..15 blank.
  function automatic logic [6:0] segDecode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // One decimal step up or down with carry/borrow rippling through the digits.
  function automatic logic [CW-1:0] bcdStep(input logic [CW-1:0] v, input logic up);
    logic [CW-1:0] r;
    logic          c;
    logic [3:0]    d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (!c) begin
        r[4*i +: 4] = d;
      end else if (up) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c           = 1'b0;
        end
      end else begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is shown if it is digit 0, at or below the dp digit, or if any
  // digit at or above it is non-zero.
  function automatic logic digitShown(input logic [CW-1:0] v, input int idx);
    logic shown;
    shown = (idx == 0) || (idx <= DP_DIGIT);
    for (int i = 0; i < DIGITS; i++) begin
      shown = shown | ((i >= idx) && (v[4*i +: 4] != 4'd0));
    end
    return shown;
  endfunction
`endif

  logic [PW-1:0] prescCnt_r;
  logic [CW-1:0] count_r;
  logic          wrap_r;
  logic          lapPrev_r;
  logic          hold_r;
  logic [CW-1:0] snap_r;
  logic [SW-1:0] scanCnt_r;
  logic [IW-1:0] scanIdx_r;
  logic [DIGITS-1:0] an_r;
  logic [7:0]    sgm_r;

  logic          tick_s;
  logic          lapRise_s;
  logic          scanPulse_s;
  logic          allNines_s;
  logic          allZero_s;
  logic [CW-1:0] dispSrc_s;
  logic [3:0]    curDigit_s;
  logic [DIGITS-1:0] anNext_s;
  logic          dpNext_s;
  logic [6:0]    segNext_s;
  logic [7:0]    sgmNext_s;

  assign tick_s      = bus.enable & (prescCnt_r == PRESC_LAST);
  assign lapRise_s   = bus.lap & ~lapPrev_r;
  assign scanPulse_s = (scanCnt_r == SCAN_LAST);
  assign allNines_s  = (count_r == ALL_NINES);
  assign allZero_s   = (count_r == ALL_ZERO);

  // Tick prescaler: advances only while enabled, so a pause keeps the phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescCnt_r <= PW'(0);
    end else if (bus.clear) begin
      prescCnt_r <= PW'(0);
    end else if (bus.enable) begin
      prescCnt_r <= (prescCnt_r == PRESC_LAST) ? PW'(0) : prescCnt_r + PW'(1);
    end
  end

  // BCD counter and wrap pulse; clear beats a coincident tick and suppresses wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= ALL_ZERO;
      wrap_r  <= 1'b0;
    end else if (bus.clear) begin
      count_r <= ALL_ZERO;
      wrap_r  <= 1'b0;
    end else if (tick_s) begin
      count_r <= bcdStep(count_r, bus.upDown);
      wrap_r  <= bus.upDown ? allNines_s : allZero_s;
    end else begin
      wrap_r  <= 1'b0;
    end
  end

  // Lap edge detect and hold toggle; entering hold captures the pre-tick live count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lapPrev_r <= 1'b0;
      hold_r    <= 1'b0;
      snap_r    <= ALL_ZERO;
    end else begin
      lapPrev_r <= bus.lap;
      if (bus.clear) begin
        hold_r <= 1'b0;
        snap_r <= ALL_ZERO;
      end else if (lapRise_s) begin
        hold_r <= ~hold_r;
        if (!hold_r) begin
          snap_r <= count_r;
        end
      end
    end
  end

  // Select the digit under the scan index and build the next anode/segment word.
  always_comb begin
    dispSrc_s  = hold_r ? snap_r : count_r;
    curDigit_s = 4'd0;
    anNext_s   = {DIGITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      curDigit_s  = curDigit_s | ((scanIdx_r == IW'(i)) ? dispSrc_s[4*i +: 4] : 4'd0);
      anNext_s[i] = (scanIdx_r == IW'(i)) ? 1'b0 : 1'b1;
    end
    dpNext_s = (int'(scanIdx_r) == DP_DIGIT) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if (digitShown(dispSrc_s, int'(scanIdx_r))) begin
      segNext_s = segDecode(curDigit_s);
    end else begin
      segNext_s = 7'h7F;
    end
`else
    segNext_s = segDecode(curDigit_s);
`endif
    sgmNext_s = {dpNext_s, segNext_s};
  end

  // Free-running scan divider; each pulse latches an/sgm and steps the digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scanCnt_r <= SW'(0);
      scanIdx_r <= IW'(0);
      an_r      <= {DIGITS{1'b1}};
      sgm_r     <= 8'hFF;
    end else begin
      scanCnt_r <= scanPulse_s ? SW'(0) : scanCnt_r + SW'(1);
      if (scanPulse_s) begin
        scanIdx_r <= (scanIdx_r == IDX_LAST) ? IW'(0) : scanIdx_r + IW'(1);
        an_r      <= anNext_s;
        sgm_r     <= sgmNext_s;
      end
    end
  end

  assign bus.count_bcd = count_r;
  assign bus.wrap      = wrap_r;
  assign bus.an        = an_r;
  assign bus.sgm       = sgm_r;

endmodule

// File: tb/tb_bcd_stopwatch_mux.sv
// Scoreboard bench for bcd_stopwatch_mux: an integer-level reference model
// pushes the expected outputs after every clock edge, a monitor pops and
// compares them on the falling edge. Directed phases plus a random phase.
module tb_bcd_stopwatch_mux;
  localparam int CLK_HZ   = 20;
  localparam int TICK_HZ  = 2;
  localparam int SCAN_HZ  = 10;
  localparam int DIGITS   = 4;
  localparam int DP_DIGIT = 2;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int SDIV     = CLK_HZ / SCAN_HZ;
  localparam int MAXV     = 9999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_stopwatch_mux_if #(.DIGITS(DIGITS)) bus();

  bcd_stopwatch_mux #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_HZ(SCAN_HZ),
    .DIGITS(DIGITS), .DP_DIGIT(DP_DIGIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0] cnt;
    logic        wrap;
    logic [3:0]  an;
    logic [7:0]  sgm;
  } exp_t;

  exp_t expQ[$];
  int nVec = 0;
  int nMis = 0;

  // reference model state (plain integers)
  int   mCount, mPresc, mSnap, mScanPh, mIdx;
  bit   mHold, mLapPrev, mWrap;
  logic [3:0] mAn;
  logic [7:0] mSgm;

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nVec++;
    if (act !== expv) begin
      nMis++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic modelReset();
    mCount = 0; mPresc = 0; mSnap = 0; mScanPh = 0; mIdx = 0;
    mHold = 1'b0; mLapPrev = 1'b0; mWrap = 1'b0;
    mAn = 4'hF; mSgm = 8'hFF;
  endtask

  // state after one rising edge, from the inputs present at that edge
  task automatic modelStep();
    int  src, d;
    bit  tick, rise, pulse;
    if (!rst) begin
      modelReset();
      return;
    end
    src   = mHold ? mSnap : mCount;
    pulse = (mScanPh == SDIV - 1);
    tick  = bus.enable && (mPresc == DIV - 1);
    rise  = bus.lap && !mLapPrev;
    if (pulse) begin
      d    = (src / pow10(mIdx)) % 10;
      mAn  = ~(4'b0001 << mIdx);
      mSgm = {((mIdx == DP_DIGIT) ? 1'b0 : 1'b1), segOf(d)};
`ifdef LEADING_ZERO_BLANK_EN
      if (mIdx > DP_DIGIT && src < pow10(mIdx)) mSgm[6:0] = 7'h7F;
`endif
      mIdx = (mIdx + 1) % DIGITS;
    end
    mScanPh  = (mScanPh + 1) % SDIV;
    mLapPrev = bus.lap;
    if (bus.clear) begin
      mCount = 0; mPresc = 0; mHold = 1'b0; mSnap = 0; mWrap = 1'b0;
    end else begin
      if (rise) begin
        if (!mHold) mSnap = mCount;
        mHold = !mHold;
      end
      mWrap = 1'b0;
      if (tick) begin
        if (bus.upDown) begin
          mWrap  = (mCount == MAXV);
          mCount = (mCount + 1) % (MAXV + 1);
        end else begin
          mWrap  = (mCount == 0);
          mCount = (mCount + MAXV) % (MAXV + 1);
        end
      end
      if (bus.enable) mPresc = (mPresc + 1) % DIV;
    end
  endtask

  task automatic cycle(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      modelStep();
      e.cnt = toBcd(mCount); e.wrap = mWrap; e.an = mAn; e.sgm = mSgm;
      expQ.push_back(e);
      #1;
    end
  endtask

  // monitor: one expected word per edge, compared on the falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("count", 32'(bus.count_bcd), 32'(e.cnt));
        check("wrap",  32'(bus.wrap),      32'(e.wrap));
        check("an",    32'(bus.an),        32'(e.an));
        check("sgm",   32'(bus.sgm),       32'(e.sgm));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [7:0] wantSgm;
    rst = 1'b0;
    bus.enable = 1'b0; bus.upDown = 1'b1; bus.clear = 1'b0; bus.lap = 1'b0;
    modelReset();
    #12;
    check("rst_count", 32'(bus.count_bcd), 32'h0);
    check("rst_wrap",  32'(bus.wrap),      32'h0);
    check("rst_an",    32'(bus.an),        32'hF);
    check("rst_sgm",   32'(bus.sgm),       32'hFF);

    // free count: 100 clocks -> 0010
    @(negedge clk);
    rst = 1'b1; bus.enable = 1'b1; bus.upDown = 1'b1;
    cycle(100);
    check("cnt100", 32'(bus.count_bcd), 32'h0010);

    // asynchronous reset mid-run
    cycle(23);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count_bcd), 32'h0);
    check("arst_wrap",  32'(bus.wrap),      32'h0);
    check("arst_an",    32'(bus.an),        32'hF);
    check("arst_sgm",   32'(bus.sgm),       32'hFF);
    cycle(3);

    // down from 0000 wraps to 9999, then back up through 9999 -> 0000
    @(negedge clk);
    rst = 1'b1; bus.enable = 1'b1; bus.upDown = 1'b0;
    cycle(10);
    check("dn_wrap_cnt", 32'(bus.count_bcd), 32'h9999);
    check("dn_wrap_pls", 32'(bus.wrap),      32'h1);
    cycle(1);
    check("dn_wrap_end", 32'(bus.wrap),      32'h0);
    cycle(9);
    check("dn_9998",     32'(bus.count_bcd), 32'h9998);
    bus.upDown = 1'b1;
    cycle(10);
    check("up_9999",     32'(bus.count_bcd), 32'h9999);
    cycle(10);
    check("up_wrap_cnt", 32'(bus.count_bcd), 32'h0000);
    check("up_wrap_pls", 32'(bus.wrap),      32'h1);
    cycle(1);
    check("up_wrap_end", 32'(bus.wrap),      32'h0);

    // pause for 37 clocks mid-period: tick lands 37 clocks later
    bus.clear = 1'b1; cycle(1); bus.clear = 1'b0;
    cycle(5);
    bus.enable = 1'b0; cycle(37);
    bus.enable = 1'b1; cycle(4);
    check("pause_pre",  32'(bus.count_bcd), 32'h0000);
    cycle(1);
    check("pause_tick", 32'(bus.count_bcd), 32'h0001);

    // lap hold at 0012, live count continues to 0017
    bus.clear = 1'b1; cycle(1); bus.clear = 1'b0;
    cycle(120);
    check("lap_at12", 32'(bus.count_bcd), 32'h0012);
    bus.lap = 1'b1;
    cycle(50);
    check("lap_live17", 32'(bus.count_bcd), 32'h0017);
    for (int k = 0; k < 8; k++) begin
      case (bus.an)
        4'b1110: wantSgm = 8'hA4;
        4'b1101: wantSgm = 8'hF9;
        4'b1011: wantSgm = 8'h40;
`ifdef LEADING_ZERO_BLANK_EN
        4'b0111: wantSgm = 8'hFF;
`else
        4'b0111: wantSgm = 8'hC0;
`endif
        default: wantSgm = 8'h00;
      endcase
      check("lap_disp", {bus.an, 20'h0, bus.sgm}, {bus.an, 20'h0, wantSgm});
      cycle(1);
    end
    bus.lap = 1'b0; cycle(2);
    bus.lap = 1'b1; cycle(12);

    // lap edge coincident with clear: clear wins
    bus.lap = 1'b0; cycle(1);
    bus.lap = 1'b1; bus.clear = 1'b1; cycle(1);
    bus.clear = 1'b0; cycle(30);

    // random phase
    for (int k = 0; k < 700; k++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.upDown = 1'($urandom_range(0, 1));
      bus.clear  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) bus.lap = ~bus.lap;
      cycle(1);
    end
    bus.clear = 1'b0;
    cycle(2);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
